// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that owns a single 5-bit Fibonacci LFSR and issues each
// stepped value to exactly one requester; also handles seeding and free-run ticks.
module lfsr_arbiter #(
  parameter int         NREQ = 4,
  parameter logic [4:0] SEED = 5'b11111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            tick,
  input  logic            seed_load,
  input  logic [4:0]      seed_val,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic [4:0]      data,
  output logic [4:0]      lfsr,
  output logic            busy,
  output logic [7:0]      tick_drop
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;

  state_t          state_q, state_d;
  logic [4:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   winner_q, winner_d;
  logic            pending_q, pending_d;
  logic [4:0]      seed_q, seed_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [4:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic [7:0]      drop_q, drop_d;

  logic [PW-1:0]   pick;
  logic            pick_found;
  logic            tick_dropped;
  int              idx;

  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return {v[0] ^ v[2], v[4:1]};
  endfunction

  // First set request at or above the pointer, wrapping past NREQ-1 to 0.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick       = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    ptr_d        = ptr_q;
    winner_d     = winner_q;
    pending_d    = pending_q;
    seed_d       = seed_q;
    gnt_d        = '0;
    valid_d      = 1'b0;
    data_d       = data_q;
    busy_d       = 1'b0;
    drop_d       = drop_q;
    tick_dropped = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          lfsr_d       = (seed_q == 5'd0) ? SEED : seed_q;
          pending_d    = 1'b0;
          tick_dropped = tick;
        end else if (|req) begin
          winner_d     = pick;
          state_d      = STEP;
          busy_d       = 1'b1;
          tick_dropped = tick;
        end else if (tick) begin
          lfsr_d = lfsr_next(lfsr_q);
        end
      end
      STEP: begin
        lfsr_d             = lfsr_next(lfsr_q);
        state_d            = RESP;
        gnt_d[winner_q]    = 1'b1;
        valid_d            = 1'b1;
        data_d             = lfsr_next(lfsr_q);
        busy_d             = 1'b1;
        tick_dropped       = tick;
      end
      RESP: begin
        ptr_d        = (winner_q == PW'(NREQ - 1)) ? '0 : winner_q + PW'(1);
        state_d      = IDLE;
        tick_dropped = tick;
      end
      default: state_d = IDLE;
    endcase

    // A fresh strobe always re-arms the seed, even on the cycle an older one is applied.
    if (seed_load) begin
      pending_d = 1'b1;
      seed_d    = seed_val;
    end

    if (tick_dropped && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      ptr_q     <= '0;
      winner_q  <= '0;
      pending_q <= 1'b0;
      seed_q    <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      pending_q <= pending_d;
      seed_q    <= seed_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign gnt       = gnt_q;
  assign valid     = valid_q;
  assign data      = data_q;
  assign lfsr      = lfsr_q;
  assign busy      = busy_q;
  assign tick_drop = drop_q;

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Round-robin arbiter and sequencer that shares one 5-bit Fibonacci LFSR (next = {b0^b2, b4:b1}, period 31) between NREQ requesters. It also handles seeding and free-run advance from the divided-clock tick strobe. It sits between the game/test logic that consumes pseudo-random values and the LFSR datapath. It owns the LFSR register, so each value is issued to exactly one requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- SEED, 5'b11111, reset value of the LFSR, also substituted for an all-zero seed
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  NREQ  level request per requester; held until its gnt bit is seen
- tick  in  1  single-cycle strobe from the clock divider requesting a free-run step
- seed_load  in  1  single-cycle strobe; capture seed_val for loading
- seed_val  in  5  seed value
- gnt  out  NREQ  one-hot grant pulse, one cycle
- valid  out  1  high with gnt; data is valid
- data  out  5  LFSR value issued to the granted requester
- lfsr  out  5  current LFSR state
- busy  out  1  high whenever the FSM is not IDLE
- tick_drop  out  8  saturating count of dropped ticks

## Operation
- Reset values (reset=0 at an edge):
  - gnt=0, valid=0, data=0, lfsr=SEED, busy=0, tick_drop=0.
  - Round-robin pointer=0, seed_pending=0, FSM=IDLE.
  - Reset wins over every other input in any state.
- FSM states: IDLE, STEP, RESP.
- IDLE, evaluated in this priority order:
  1. seed_pending=1: load lfsr with the captured seed; all-zero seed loads SEED instead. Clear seed_pending and stay IDLE. Requests wait one cycle.
  2. Else any req bit high: winner is the first set bit searching from the pointer upward, wrapping at NREQ-1 to 0. Register the winner and go to STEP.
  3. Else tick=1: lfsr <= next(lfsr) and stay IDLE. No valid.
- STEP: lfsr <= next(lfsr); go to RESP.
- RESP:
  - gnt[winner]=1, valid=1, data=lfsr. This is the value produced in STEP.
  - Pointer <= (winner+1) mod NREQ.
  - Go to IDLE.
- seed_load in any cycle (including during reset-free STEP/RESP):
  - Sets seed_pending and captures seed_val.
  - A second load before application overwrites the captured value.
  - seed_load with pending=0 in the same IDLE cycle as a req: the req is served first; the seed is applied at the next IDLE.
- A tick is dropped and tick_drop increments (saturating at 255) when any of these hold:
  - it arrives in STEP or RESP;
  - it arrives in IDLE while seed_pending=1;
  - it arrives in IDLE while any req is high.
- Only the FSM changes lfsr; there is no other write path. data holds its last value when valid=0.

## Timing
- All outputs are registered.
- Request latency:
  - req high before edge E0 in IDLE → STEP after E0.
  - After E1: RESP, with gnt/valid/data high for exactly one cycle.
  - After E2: IDLE.
- Throughput: one grant per 3 cycles per arbiter.
- Requester rule:
  - Must drive req low in the cycle after it sees gnt, i.e. a registered deassert on gnt.
  - A req still high in IDLE is treated as a new request.
- Fairness: every continuously asserted req is granted within NREQ grants.
- Seed latency:
  - Strobe at edge Es sets pending.
  - Loaded at the end of the first IDLE cycle after Es.
- busy=1 exactly in STEP and RESP.

## Test plan
- Reset, then req=4'b0001 held for 1 cycle: gnt=0001 and valid=1 two edges later, data=01111, lfsr=01111, busy=1 for 2 cycles.
- req=4'b1111 held, each bit dropped after its gnt: grants arrive in order 0001, 0010, 0100, 1000 with data 01111, 00111, 00011, 10001, spaced 3 cycles apart.
- tick in IDLE with req=0 → lfsr 11111→01111, valid stays 0. tick during STEP → tick_drop=1, and the value returned in RESP is unaffected. 31 IDLE ticks from reset → lfsr=11111.
- seed_load with seed_val=00000 → lfsr=11111. seed_load with 10101 during RESP → loaded in the next IDLE cycle; a following req returns data=01010.
- NREQ=4, pointer=2 after a grant to 1, req=1011 → grant order 3, 0, 1.
- reset=0 asserted during STEP → next cycle: gnt=0, valid=0, lfsr=11111, busy=0, pointer=0, pending seed discarded.
